// File: rtl/des_sbox_engine.sv
// DES substitution stage: maps a 48-bit expanded word through S1..S8 into a 32-bit word,
// performing LANES S-box lookups per cycle behind a valid/ready handshake on both sides.
`timescale 1ns/1ps
module des_sbox_engine #(
  parameter int LANES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy
);

  localparam int STEPS = (LANES > 0) ? 8 / LANES : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // One entry per box; rows 0..3 from MSB down, 16 nibbles per row, column 0 leftmost.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] chunk);
    logic [5:0] idx;
    idx = {chunk[5], chunk[0], chunk[4:1]};
    return 4'(SBOX[box] >> {6'd63 - idx, 2'b00});
  endfunction

  state_t        state;
  logic [CW-1:0] step;
  logic [47:0]   in_reg;
  logic [31:0]   data_next;
  logic [2:0]    box;
  logic [5:0]    chunk;

  // Lane j at step c handles box c*LANES+j; every other nibble keeps its current value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    data_next = o_data;
    box       = '0;
    chunk     = '0;
    for (int j = 0; j < LANES; j++) begin
      box   = 3'(int'(step) * LANES + j);
      chunk = 6'(in_reg >> (6 * (7 - int'(box))));
      data_next[4 * (7 - int'(box)) +: 4] = sbox_lookup(box, chunk);
    end
  end

  assign o_ready = (state == IDLE) || ((state == DONE) && i_ready);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the input register is cleared too, so an aborted word leaves nothing behind.
      state   <= IDLE;
      step    <= '0;
      in_reg  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            in_reg <= i_data;
            step   <= '0;
            o_busy <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          o_data <= data_next;
          if (step == LAST_STEP) begin
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            step <= step + CW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_valid) begin
              in_reg <= i_data;
              step   <= '0;
              o_busy <= 1'b1;
              state  <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Self-checking bench for des_sbox_engine: one instance per legal LANES value, a shared
// scoreboard queue fed by the stimulus and drained by an output monitor.
`timescale 1ns/1ps
module tb_des_sbox_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] d [4];
  logic [31:0] od [4];
  logic [3:0]  iv, ir, ordy, ov, ob;

  always #5 clk = ~clk;

  // Instance g runs with LANES = 1 << g.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_engine #(.LANES(1 << g)) u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_data (d[g]),
      .i_valid(iv[g]),
      .o_ready(ordy[g]),
      .o_data (od[g]),
      .o_valid(ov[g]),
      .i_ready(ir[g]),
      .o_busy (ob[g])
    );
  end

  // Reference S-boxes, entry box*4+row, 16 nibbles per row with column 0 leftmost.
  localparam logic [63:0] REF_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [31:0] ref_model(input logic [47:0] w);
    logic [31:0] r;
    logic [5:0]  c;
    logic [63:0] row_bits;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      c        = w[47 - 6 * b -: 6];
      row_bits = REF_ROWS[b * 4 + int'({c[5], c[0]})];
      r[31 - 4 * b -: 4] = row_bits[63 - 4 * int'(c[4:1]) -: 4];
    end
    return r;
  endfunction

  typedef struct {
    int          idx;
    logic [47:0] data;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  int          sel = 0;
  bit          mon_en = 1'b0;
  int          received = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h lanes_idx=%0d t=%0t", name, act, exp, sel, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rand48();
    return {16'($urandom), $urandom};
  endfunction

  // Output monitor: pops the scoreboard on every output handshake and checks hold-stability.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) begin
        check("hold_valid", 64'(ov[sel]), 64'd1);
        check("hold_data", 64'(od[sel]), 64'(prev_data));
      end
      if (ov[sel] && ir[sel]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: actual=%0h expected=none lanes_idx=%0d t=%0t", od[sel], sel, $time);
        end else begin
          check("sb_data", 64'(od[sel]), 64'(exp_q.pop_front()));
          received++;
        end
      end
      prev_hold = ov[sel] && !ir[sel];
      prev_data = od[sel];
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // One word with the downstream always ready: latency, busy length, single-cycle valid.
  task automatic run_vector(input vec_t v);
    int steps, lat, busy;
    sel   = v.idx;
    steps = 8 >> v.idx;
    ir[sel] = 1'b1;
    check("idle_ready", 64'(ordy[sel]), 64'd1);
    d[sel]  = v.data;
    iv[sel] = 1'b1;
    exp_q.push_back(v.exp);
    tick();
    iv[sel] = 1'b0;
    d[sel]  = rand48();
    lat  = 0;
    busy = 0;
    while (!ov[sel] && lat < 20) begin
      if (ob[sel]) busy++;
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(steps));
    check("busy_cycles", 64'(busy), 64'(steps));
    tick();
    check("valid_single", 64'(ov[sel]), 64'd0);
    check("back_idle_ready", 64'(ordy[sel]), 64'd1);
    check("idle_not_busy", 64'(ob[sel]), 64'd0);
    drain();
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    vec_t vecs [10];
    logic [47:0] words [4];
    int n_acc, cyc, last_acc, sent, rcv0, budget;
    bit acc;

    // S7 chunk 000001 addresses row 1, column 0 (13); S8 chunk 000000 gives 13.
    vecs[0] = '{0, 48'h0,              32'hEFA72C4D};
    vecs[1] = '{1, 48'h0,              32'hEFA72C4D};
    vecs[2] = '{2, 48'h0,              32'hEFA72C4D};
    vecs[3] = '{3, 48'h0,              32'hEFA72C4D};
    vecs[4] = '{0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB};
    vecs[5] = '{1, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB};
    vecs[6] = '{2, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB};
    vecs[7] = '{3, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB};
    vecs[8] = '{2, 48'h0000_0000_0040, 32'hEFA72CDD};
    vecs[9] = '{3, 48'h1234_5678_9ABC, ref_model(48'h1234_5678_9ABC)};

    rst = 1'b1;
    iv  = '0;
    ir  = '0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = i;
      check("rst_ready", 64'(ordy[i]), 64'd1);
      check("rst_valid", 64'(ov[i]), 64'd0);
      check("rst_busy", 64'(ob[i]), 64'd0);
      check("rst_data", 64'(od[i]), 64'd0);
    end
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) run_vector(vecs[i]);

    // Backpressure on LANES=2: result held, no accept while upstream keeps offering words.
    sel = 1;
    ir[1] = 1'b0;
    d[1]  = 48'h0000_0000_0040;
    iv[1] = 1'b1;
    exp_q.push_back(32'hEFA72CDD);
    tick();
    d[1] = rand48();
    cyc = 0;
    while (!ov[1] && cyc < 20) begin
      tick();
      d[1] = rand48();
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(ov[1]), 64'd1);
      check("bp_data", 64'(od[1]), 64'hEFA72CDD);
      check("bp_ready", 64'(ordy[1]), 64'd0);
      tick();
      d[1] = rand48();
    end
    ir[1] = 1'b1;
    iv[1] = 1'b0;
    tick();
    check("bp_release", 64'(ov[1]), 64'd0);
    drain();

    // Reset at step 4 of a LANES=1 word, then a clean word afterwards.
    sel = 0;
    ir[0] = 1'b1;
    d[0]  = 48'hFFFF_FFFF_FFFF;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    check("abort_busy", 64'(ob[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 64'(ordy[0]), 64'd1);
    check("abort_valid", 64'(ov[0]), 64'd0);
    check("abort_data", 64'(od[0]), 64'd0);
    check("abort_busy_clr", 64'(ob[0]), 64'd0);
    run_vector('{0, 48'h0, 32'hEFA72C4D});

    // Back-to-back stream on LANES=4: each accept lands in the previous word's DONE cycle.
    sel = 2;
    for (int i = 0; i < 4; i++) words[i] = rand48();
    ir[2] = 1'b1;
    d[2]  = words[0];
    iv[2] = 1'b1;
    n_acc = 0;
    cyc = 0;
    last_acc = 0;
    while (n_acc < 4 && cyc < 60) begin
      @(negedge clk);
      acc = iv[2] && ordy[2];
      if (acc) begin
        exp_q.push_back(ref_model(d[2]));
        if (n_acc > 0) begin
          check("b2b_in_done", 64'(ov[2]), 64'd1);
          check("b2b_period", 64'(cyc - last_acc), 64'd3);
        end
        last_acc = cyc;
        n_acc++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (n_acc < 4) d[2] = words[n_acc];
        else iv[2] = 1'b0;
      end
    end
    iv[2] = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd4);
    drain();

    // Random valid/ready traffic at every LANES value.
    for (int idx = 0; idx < 4; idx++) begin
      sel    = idx;
      sent   = 0;
      rcv0   = received;
      acc    = 1'b0;
      cyc    = 0;
      budget = 150 * ((8 >> idx) + 1) * 8 + 200;
      while (sent < 150 && cyc < budget) begin
        tick();
        cyc++;
        if (!iv[idx] || acc) begin
          iv[idx] = (sent < 150) && ($urandom_range(2) != 0);
          d[idx]  = rand48();
        end
        ir[idx] = ($urandom_range(2) != 0);
        @(negedge clk);
        acc = iv[idx] && ordy[idx];
        if (acc) begin
          exp_q.push_back(ref_model(d[idx]));
          sent++;
        end
      end
      tick();
      iv[idx] = 1'b0;
      ir[idx] = 1'b1;
      check("rand_sent", 64'(sent), 64'd150);
      drain();
      check("rand_received", 64'(received - rcv0), 64'd150);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
